// File: rtl/sha_pkg.sv
// Shared constants, block-count helper and sequencer state type for the SHA-256 input stage.
package sha_pkg;

  localparam int SHA_BLK_BITS = 512;
  localparam int SHA_LEN_BITS = 64;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EMIT = 2'd1,
    ST_DONE = 2'd2
  } seq_state_t;

  // Blocks needed for an l-bit message plus the '1' marker bit and the 64-bit length field.
  function automatic int sha_nblocks(input int l);
    return (l + SHA_LEN_BITS + 1 + SHA_BLK_BITS - 1) / SHA_BLK_BITS;
  endfunction

endpackage

// File: rtl/sha_pad_builder.sv
// Combinational builder of the padded message {hdr, nonce, 1, 0..0, L}; returns 512-bit block idx.
module sha_pad_builder
  import sha_pkg::*;
#(
  parameter int HDR_BITS   = 608,
  parameter int NONCE_BITS = 32,
  parameter int NBLK       = 2,
  parameter int IDX_W      = 1
) (
  input  logic [HDR_BITS-1:0]     hdr,
  input  logic [NONCE_BITS-1:0]   nonce,
  input  logic [IDX_W-1:0]        idx,
  output logic [SHA_BLK_BITS-1:0] blk
);

  localparam int                      L   = HDR_BITS + NONCE_BITS;
  localparam int                      PW  = NBLK * SHA_BLK_BITS;
  localparam logic [SHA_LEN_BITS-1:0] LEN = SHA_LEN_BITS'(L);

  logic [PW-1:0] msg;

  always_comb begin
    msg = '0;
    msg[PW-1 -: HDR_BITS]            = hdr;
    msg[PW-1-HDR_BITS -: NONCE_BITS] = nonce;
    msg[PW-1-L]                      = 1'b1;
    msg[SHA_LEN_BITS-1:0]            = LEN;
  end

  // Block 0 is the most significant slice, so the first message bit leaves first.
  always_comb begin
    blk = '0;
    for (int k = 0; k < NBLK; k++) begin
      if (idx == IDX_W'(k)) blk = msg[PW-1-k*SHA_BLK_BITS -: SHA_BLK_BITS];
    end
  end

endmodule

// File: rtl/sha_block_sequencer.sv
// SHA-256 input stage: streams the padded message for one nonce, or a nonce sweep, as 512-bit blocks.
module sha_block_sequencer
  import sha_pkg::*;
#(
  parameter int HDR_BITS   = 608,
  parameter int NONCE_BITS = 32
) (
  input  logic                    clk,
  input  logic                    n_rst,
  input  logic                    start,
  input  logic                    sweep,
  input  logic                    stop,
  input  logic [HDR_BITS-1:0]     hdr,
  input  logic [NONCE_BITS-1:0]   nonce_start,
  input  logic [NONCE_BITS-1:0]   nonce_end,
  output logic [SHA_BLK_BITS-1:0] blk_data,
  output logic                    blk_valid,
  input  logic                    blk_ready,
  output logic                    blk_first,
  output logic                    blk_last,
  output logic [NONCE_BITS-1:0]   blk_nonce,
  output logic                    busy,
  output logic                    done,
  output logic                    wrapped
);

  localparam int                L        = HDR_BITS + NONCE_BITS;
  localparam int                NBLK     = sha_nblocks(L);
  localparam int                IDX_W    = (NBLK > 1) ? $clog2(NBLK) : 1;
  localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(NBLK - 1);

  // Widths are int, so L always fits the 64-bit length field; only the ranges need guarding.
  if (NONCE_BITS < 1 || NONCE_BITS > 32 || HDR_BITS < 1) begin : g_param_chk
    $error("sha_block_sequencer: HDR_BITS must be >= 1 and NONCE_BITS in 1..32");
  end

  seq_state_t              state_q, state_d;
  logic [HDR_BITS-1:0]     hdr_q;
  logic [NONCE_BITS-1:0]   nonce_q;
  logic [NONCE_BITS-1:0]   nonce_end_q;
  logic                    sweep_q;
  logic                    stop_q;
  logic                    wrapped_q;
  logic [IDX_W-1:0]        idx_q;
  logic [SHA_BLK_BITS-1:0] pad_blk;
  logic                    xfer;
  logic                    at_last;
  logic                    job_end;

  sha_pad_builder #(
    .HDR_BITS  (HDR_BITS),
    .NONCE_BITS(NONCE_BITS),
    .NBLK      (NBLK),
    .IDX_W     (IDX_W)
  ) u_pad (
    .hdr  (hdr_q),
    .nonce(nonce_q),
    .idx  (idx_q),
    .blk  (pad_blk)
  );

  assign blk_valid = (state_q == ST_EMIT);
  assign busy      = (state_q != ST_IDLE);
  assign done      = (state_q == ST_DONE);
  assign xfer      = blk_valid & blk_ready;
  assign at_last   = (idx_q == LAST_IDX);
  // A stop arriving with the last transfer still ends the job without starting the next nonce.
  assign job_end   = !sweep_q || (nonce_q == nonce_end_q) || stop_q || stop;

  assign blk_data  = blk_valid ? pad_blk : '0;
  assign blk_first = blk_valid && (idx_q == '0);
  assign blk_last  = blk_valid && at_last;
  assign blk_nonce = nonce_q;
  assign wrapped   = wrapped_q;

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (start) state_d = ST_EMIT;
      ST_EMIT: if (xfer && at_last && job_end) state_d = ST_DONE;
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!n_rst) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  always_ff @(posedge clk) begin
    if (!n_rst) begin
      hdr_q       <= '0;
      nonce_q     <= '0;
      nonce_end_q <= '0;
      sweep_q     <= 1'b0;
      stop_q      <= 1'b0;
      wrapped_q   <= 1'b0;
      idx_q       <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            hdr_q       <= hdr;
            nonce_q     <= nonce_start;
            nonce_end_q <= nonce_end;
            sweep_q     <= sweep;
            stop_q      <= 1'b0;
            wrapped_q   <= 1'b0;
            idx_q       <= '0;
          end
        end
        ST_EMIT: begin
          if (stop) stop_q <= 1'b1;
          if (xfer) begin
            if (!at_last) begin
              idx_q <= idx_q + 1'b1;
            end else if (!job_end) begin
              // Next nonce starts immediately so the stream has no bubble between messages.
              nonce_q <= nonce_q + 1'b1;
              idx_q   <= '0;
              if (&nonce_q) wrapped_q <= 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule
